delay_pulse: RTL and testbench



---
 rtl/delay_pulse.sv | 55 +++++
 tb/tb_delay_pulse.sv | 138 +++++++++++++
 2 files changed

// File: rtl/delay_pulse.sv
// Runtime-programmable strobe delay: pending pulses are held as a FIFO of
// target timestamps against a free-running timer, emitted in order on q.
module delay_pulse #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DW-1:0]              delay,
   input  logic                       d,
   input  logic                       ovf_clr,
   output logic                       q,
   output logic [$clog2(DEPTH):0]     pending,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DW-1:0] tmr;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, push, drop;

   assign full = (pending == PW'(DEPTH));
   assign pop  = (pending != '0) && (mem[rd_ptr] == tmr);
   // a pop frees the head slot this cycle, so a full FIFO still accepts
   assign push = d && (!full || pop);
   assign drop = d && full && !pop;

   // +1 makes the head compare start at n+1, so D=2^DW-1 is still reachable
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tmr + delay + DW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pending <= '0;
         q       <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         tmr     <= tmr + DW'(1);
         q       <= pop;
         pending <= pending + PW'(push) - PW'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_delay_pulse.sv
// Directed bench for delay_pulse: expected q cycles are queued when pulses are
// driven and retired as the cycle count reaches them.
module tb_delay_pulse;

   localparam int DEPTH = 4;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] delay;
   logic          d;
   logic          ovf_clr;
   logic          q;
   logic [2:0]    pending;
   logic          ovf;

   delay_pulse #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .delay(delay), .d(d), .ovf_clr(ovf_clr),
      .q(q), .pending(pending), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   base  = 0;
   int   exp_q[$];
   logic exp_ovf = 1'b0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // drive one cycle of inputs, predict, clock, then check outputs
   task automatic step(input bit dv, input int dd, input bit clr);
      bit   pop_now, acc, exp_qv;
      logic nxt_ovf;
      d       = dv;
      delay   = dd[7:0];
      ovf_clr = clr;
      pop_now = (exp_q.size() > 0) && (exp_q[0] == cyc + 1);
      acc     = dv && ((exp_q.size() < DEPTH) || pop_now);
      if (acc) exp_q.push_back(cyc + dd + 2);
      nxt_ovf = (dv && !acc) ? 1'b1 : (clr ? 1'b0 : exp_ovf);
      @(posedge clk);
      cyc++;
      #1;
      exp_ovf = nxt_ovf;
      exp_qv  = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_qv) void'(exp_q.pop_front());
      chk("q", {7'd0, q}, {7'd0, exp_qv});
      chk("pending", {5'd0, pending}, 8'(exp_q.size()));
      chk("ovf", {7'd0, ovf}, {7'd0, exp_ovf});
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() > 0 || guard < 3) && guard < 2000) begin
         step(0, 0, 0);
         guard++;
      end
      chk("drained", 8'(exp_q.size()), 8'd0);
   endtask

   initial begin
      rst_n = 1'b0; d = 1'b0; ovf_clr = 1'b0; delay = '0;
      #12;
      chk("rst_q", {7'd0, q}, 8'd0);
      chk("rst_pending", {5'd0, pending}, 8'd0);
      chk("rst_ovf", {7'd0, ovf}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic latency: D=0, 5, 255
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      step(1, 0, 0);   drain();
      step(1, 5, 0);   drain();
      step(1, 255, 0); drain();

      // burst of 4 at D=20
      for (int i = 0; i < 4; i++) step(1, 20, 0);
      drain();

      // overflow: 6 pulses into depth 4, then clear
      for (int i = 0; i < 6; i++) step(1, 50, 0);
      for (int i = 0; i < 54; i++) step(0, 50, 0);
      step(0, 50, 1);
      drain();

      // drop coincident with clear: set wins
      for (int i = 0; i < 4; i++) step(1, 50, 0);
      step(1, 50, 1);
      step(0, 50, 1);
      drain();

      // continuous push+pop at full occupancy
      for (int i = 0; i < 20; i++) step(1, 3, 0);
      drain();

      // reset mid-flight with pulses pending and ovf set
      for (int i = 0; i < 5; i++) step(1, 100, 0);
      step(0, 100, 0);
      chk("pre_rst_pending", {5'd0, pending}, 8'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_q", {7'd0, q}, 8'd0);
      chk("arst_pending", {5'd0, pending}, 8'd0);
      chk("arst_ovf", {7'd0, ovf}, 8'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      base = cyc;

      // timer wrap: pulse at T=250, D=10
      while (cyc - base < 250) step(0, 10, 0);
      step(1, 10, 0);
      while (cyc - base < 300) step(0, 10, 0);
      step(1, 4, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
